scan_sequencer_3b: RTL

Sequential channel scanner that produces the 3-bit select `I[2:0]` and enable `En` driving the 3-to-8 dataflow decoder directly downstream. On a start pulse it steps through the channels enabled in an 8-bit mask, in ascending order, holding each selected channel for a programmable dwell time. It runs either one pass or continuously until stopped. Used for multiplexed display and strobe scanning, where the decoder converts `I`/`En` into one-hot line selects.

---
 rtl/scan_sequencer_3b.sv | 134 +++++++++++++
 1 files changed

// File: rtl/scan_sequencer_3b.sv
// scan_sequencer_3b
// Steps a 3-bit decoder select through the channels enabled in an 8-bit
// mask, lowest index first. Each channel is held for a programmable dwell
// time. The scan runs once or repeats until stopped. Every output is
// registered, so the downstream decoder receives glitch-free select and
// enable lines.
module scan_sequencer_3b #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               Start,
   input  logic               Stop,
   input  logic [7:0]         Mask,
   input  logic [DWELL_W-1:0] Dwell,
   input  logic               Mode,
   output logic [2:0]         I,
   output logic               En,
   output logic               Done,
   output logic               Wrap
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DWELL = 1'b1;

   logic [0:0]         state;
   logic [7:0]         sh_mask;
   logic [DWELL_W-1:0] sh_dwell;
   logic               sh_mode;
   logic [DWELL_W-1:0] cnt;

   logic               start_found;
   logic [2:0]         start_idx;
   logic               next_found;
   logic [2:0]         next_idx;
   logic [2:0]         wrap_idx;
   logic [3:0]         hit_start;
   logic [3:0]         hit_next;
   logic [3:0]         hit_wrap;

   // Lowest set bit of m whose index is strictly above floor. The result is
   // {found, index}. Pass floor = -1 to get the lowest set bit overall.
   function automatic logic [3:0] lowest_above(input logic [7:0] m, input int floor);
      logic [3:0] res;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (i > floor)) res = {1'b1, 3'(i)};
      end
      return res;
   endfunction

   // The counter runs down to zero, so it is loaded with max(d,1)-1. With
   // d = all-ones this gives 2^DWELL_W-1 cycles and the counter never overflows.
   function automatic logic [DWELL_W-1:0] reload_of(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - DWELL_W'(1);
   endfunction

   // Channel search. Three priority searches: the first channel of the live
   // mask at Start, the next channel above I, and the first channel of a new pass.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so that no path leaves it unassigned and no latch is inferred.
      hit_start   = lowest_above(Mask, -1);
      hit_next    = lowest_above(sh_mask, int'(I));
      hit_wrap    = lowest_above(sh_mask, -1);
      start_found = hit_start[3];
      start_idx   = hit_start[2:0];
      next_found  = hit_next[3];
      next_idx    = hit_next[2:0];
      wrap_idx    = hit_wrap[2:0];
   end

   // Sequencer state, shadow configuration, dwell counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shadow configuration is reset together with the control state, so that a scan never starts from unknown settings.
         state    <= ST_IDLE;
         sh_mask  <= '0;
         sh_dwell <= '0;
         sh_mode  <= 1'b0;
         cnt      <= '0;
         I        <= 3'd0;
         En       <= 1'b0;
         Done     <= 1'b0;
         Wrap     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only. The pulse defaults below are then overridden cleanly by later branches.
         Done <= 1'b0;
         Wrap <= 1'b0;
         case (state)
            ST_IDLE: begin
               En <= 1'b0;
               if (Start && !Stop) begin
                  if (start_found) begin
                     sh_mask  <= Mask;
                     sh_dwell <= Dwell;
                     sh_mode  <= Mode;
                     I        <= start_idx;
                     cnt      <= reload_of(Dwell);
                     En       <= 1'b1;
                     state    <= ST_DWELL;
                  end else begin
                     Done <= 1'b1;
                  end
               end
            end
            ST_DWELL: begin
               if (Stop) begin
                  state <= ST_IDLE;
                  En    <= 1'b0;
                  Done  <= 1'b1;
               end else if (cnt != '0) begin
                  cnt <= cnt - DWELL_W'(1);
               end else if (next_found) begin
                  I   <= next_idx;
                  cnt <= reload_of(sh_dwell);
               end else if (sh_mode) begin
                  I    <= wrap_idx;
                  cnt  <= reload_of(sh_dwell);
                  Wrap <= 1'b1;
               end else begin
                  state <= ST_IDLE;
                  En    <= 1'b0;
                  Done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               En    <= 1'b0;
            end
         endcase
      end
   end

endmodule
